sq_req_feeder: RTL
==================

// Module: sq_req_feeder
// PURPOSE
//  Upstream request scheduler for the square-accumulator stage. Accepts N requests on a
//  valid/ready port, buffers them in a small FIFO and issues them to the accumulator one at a
//  time: drives N plus a one-cycle N_valid, then waits for the accumulator's sum_valid before
//  launching the next job. Requests whose result would overflow the 8-bit sum are rejected.
// PARAMETERS
//  DEPTH        4    FIFO entries, power of 2, >=2
//  MAX_N        8    largest N forwarded; sum of squares 1..8 = 204 fits 8 bits, 9 -> 285 does not
//  WDOG_CYCLES  128  watchdog limit in WAIT; used only with SQ_FEED_WATCHDOG_EN
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high; clears all state
//  req_n       in   4   requested N
//  req_valid   in   1   request present
//  req_ready   out  1   = (fifo_count < DEPTH); handshake when req_valid & req_ready
//  acc_N       out  4   N to accumulator; registered, held stable from launch until sum_valid
//  acc_N_valid out  1   one-cycle launch strobe to accumulator
//  acc_sum_valid in 1   accumulator done strobe
//  busy        out  1   high in LAUNCH/WAIT
//  fifo_count  out  $clog2(DEPTH+1)  entries held
//  drop_err    out  1   one-cycle pulse: request rejected (req_n > MAX_N)
//  wdog_err    out  1   one-cycle pulse: watchdog abort (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, acc_N=0, acc_N_valid=0, busy=0, drop_err=0, wdog_err=0;
//   req_ready=1 from the first cycle after reset deassertion.
//  Accept: on handshake, req_n<=MAX_N is pushed; req_n>MAX_N is consumed (not pushed) and
//   drop_err pulses in the following cycle. N=0 is legal and is forwarded.
//  FSM (2-bit state):
//   IDLE   : if fifo_count>0, pop head into acc_N -> LAUNCH; else stay.
//   LAUNCH : acc_N_valid=1 for exactly this cycle -> WAIT.
//   WAIT   : acc_sum_valid=1 -> IDLE (next job can launch on the following cycle, when the
//            accumulator has returned to idle).
//  Latency: into an empty FIFO with FSM in IDLE, a request accepted in cycle t gives acc_N_valid
//   in cycle t+2.
//  Full: req_ready=0 when fifo_count==DEPTH, even if a pop happens in the same cycle (no
//   bypass). Simultaneous push and pop below full: count unchanged, both take effect.
//  Pointers wrap modulo DEPTH; FIFO order is strictly preserved.
//  acc_sum_valid in IDLE/LAUNCH is ignored (no state change, no error).
//  Reset mid-job: job and FIFO contents are discarded. The accumulator shares this reset.
// CONFIGURATION
//  SQ_FEED_WATCHDOG_EN defined: a counter clears on entering WAIT and increments each WAIT cycle.
//   If it reaches WDOG_CYCLES with no acc_sum_valid: -> IDLE, wdog_err pulses 1 cycle, job dropped.
//   acc_sum_valid in the same cycle as the timeout wins (normal completion, no wdog_err).
//  Not defined: no counter; WAIT holds indefinitely; wdog_err is tied 0.
// STRUCTURE
//  Package sq_pkg: SQ_N_W=4, SQ_SUM_W=8, feeder state encoding (IDLE/LAUNCH/WAIT).
//  Sub-module sq_req_fifo: sync FIFO with DEPTH parameter, push/pop/count/full/empty ports.
//  The top holds the FSM, the acc_N register, the range check and the optional watchdog.
// TESTING
//  Single req N=3 -> acc_N=3, acc_N_valid high for 1 cycle at t+2; busy until sum_valid.
//  Push 2,5,8,1 back-to-back with DEPTH=4 -> launched in order; each waits for its sum_valid.
//  With sum_valid withheld, fill the FIFO (5 reqs) -> req_ready=0 at count=4; 5th accepted
//   only after a pop.
//  req_n=9 and req_n=15 -> drop_err pulses, count unchanged, no launch; N=0 -> launched.
//  Assert reset while in WAIT with 2 queued -> all outputs at reset values, FIFO empty.
//  With SQ_FEED_WATCHDOG_EN and WDOG_CYCLES=16, no sum_valid -> wdog_err after 16 WAIT
//   cycles, next job launches; without the macro -> stays in WAIT.

Source files
------------

// File: rtl/sq_pkg.sv
// sq_pkg: shared widths and feeder state encoding for the square-accumulator request path.
package sq_pkg;
  localparam int SQ_N_W   = 4;
  localparam int SQ_SUM_W = 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
endpackage

// File: rtl/sq_req_fifo.sv
// sq_req_fifo: synchronous FIFO, DEPTH a power of 2 so pointers wrap naturally.
module sq_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/sq_req_feeder.sv
// sq_req_feeder: queues N requests and issues them one at a time to the square accumulator.
// Optional WAIT-state watchdog enabled by defining SQ_FEED_WATCHDOG_EN.
module sq_req_feeder
  import sq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_N       = 8,
  parameter int WDOG_CYCLES = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SQ_N_W-1:0]          req_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  output logic [SQ_N_W-1:0]          acc_N,
  output logic                       acc_N_valid,
  input  logic                       acc_sum_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       drop_err,
  output logic                       wdog_err
);
  logic [1:0]        state_q, state_d;
  logic [SQ_N_W-1:0] acc_n_q, acc_n_d, fifo_dout;
  logic              drop_q, drop_d, wdog_q, timeout;
  logic              full, empty, push, pop, hs, in_range;
  assign in_range = int'(req_n) <= MAX_N;
  assign req_ready = !full;
  assign hs = req_valid && req_ready;
  assign push = hs && in_range;
  assign drop_d = hs && !in_range;
  assign pop = state_q == ST_IDLE && !empty;
  sq_req_fifo #(.DEPTH(DEPTH), .W(SQ_N_W)) u_fifo (
    .clk(clk), .rst(reset), .push_i(push), .pop_i(pop), .din_i(req_n),
    .dout_o(fifo_dout), .count_o(fifo_count), .full_o(full), .empty_o(empty)
  );
`ifdef SQ_FEED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES+1);
  logic [WW-1:0] wcnt_q;
  // completion in the timeout cycle takes priority, so timeout requires no sum_valid
  assign timeout = state_q == ST_WAIT && !acc_sum_valid && wcnt_q == WW'(WDOG_CYCLES-1);
  always_ff @(posedge clk or posedge reset)
    if (reset) wcnt_q <= '0;
    else wcnt_q <= state_q == ST_WAIT ? wcnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = pop ? ST_LAUNCH :
              state_q == ST_LAUNCH ? ST_WAIT :
              (state_q == ST_WAIT && !acc_sum_valid && !timeout) ? ST_WAIT : ST_IDLE;
    acc_n_d = pop ? fifo_dout : acc_n_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      acc_n_q <= '0;
      drop_q  <= 1'b0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_n_q <= acc_n_d;
      drop_q  <= drop_d;
      wdog_q  <= timeout;
    end
  assign acc_N       = acc_n_q;
  assign acc_N_valid = state_q == ST_LAUNCH;
  assign busy        = state_q == ST_LAUNCH || state_q == ST_WAIT;
  assign drop_err    = drop_q;
  assign wdog_err    = wdog_q;
endmodule
